execute_pipe: RTL and testbench
===============================

EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width, SHALL be 8..64.
REQ-002 Parameter PC_W, default 16, program-counter width, SHALL be 8..32.
REQ-003 Port clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port in_valid  input  1 / in_ready  output  1  upstream handshake; transfer when both high.
REQ-006 Port pc_in  input  PC_W  PC of incoming instruction.
REQ-007 Port op_a, op_b  input  DATA_W each  register read data.
REQ-008 Port imm  input  16  immediate, sign-extended to DATA_W or PC_W as used.
REQ-009 Port a_imm, b_imm  input  1 each  select imm instead of op_a/op_b as ALU operand.
REQ-010 Port alu_op  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 MUL, 9-15 pass operand B.
REQ-011 Port is_jump, is_branch  input  1 each; br_cond  input  3  0 EQ, 1 NE, 2 LT, 3 GE, 4 ALWAYS, 5-7 never.
REQ-012 Port out_valid  output  1 / out_ready  input  1  downstream handshake.
REQ-013 Port alu_out  output  DATA_W; pc_out  output  PC_W; flush  output  1; flags  output  4 {Z,N,C,V}.

Function
REQ-014 Shift amount SHALL be operand B low log2(DATA_W) bits; ADD/SUB wrap modulo 2^DATA_W.
REQ-015 ADD/SUB SHALL update flags register at transfer: Z result zero, N result MSB, C carry-out (SUB: no borrow), V signed overflow; other ops SHALL leave flags unchanged.
REQ-016 Branch condition SHALL use flags register value before the current instruction: EQ Z, NE !Z, LT N^V, GE !(N^V).
REQ-017 Taken branch: pc_out = pc_in + sext(imm) mod 2^PC_W; jump: pc_out = op_a[PC_W-1:0], always taken; is_jump takes priority over is_branch; not taken: pc_out = pc_in + 1 mod 2^PC_W.
REQ-018 flush SHALL be high exactly while out_valid is high for a taken branch/jump result, low otherwise.
REQ-019 Non-MUL ops: results registered; out_valid SHALL rise the cycle after transfer (latency 1).
REQ-020 FSM states IDLE, MUL, HOLD: IDLE->MUL on accepted MUL; MUL->HOLD after exactly DATA_W iterations (shift-add, low DATA_W bits of product); HOLD->IDLE when out_valid && out_ready.
REQ-021 Non-MUL transfers SHALL go IDLE->HOLD; HOLD with simultaneous new transfer (out_ready high) SHALL stay HOLD with new result (full throughput).
REQ-022 in_ready = (state==IDLE) || (state==HOLD && out_ready); low throughout MUL.
REQ-023 Outputs alu_out, pc_out, flush, out_valid SHALL be stable while out_valid && !out_ready.
REQ-024 MUL latency SHALL be DATA_W+1 cycles from transfer to out_valid.

Reset
REQ-025 rst SHALL force state IDLE, out_valid 0, flush 0, alu_out 0, pc_out 0, flags 0, in_ready 1 the following cycle.
REQ-026 rst during MUL or HOLD SHALL abort the operation; the result SHALL never be presented.
REQ-027 rst SHALL take priority over a simultaneous transfer.

Configuration
REQ-028 Macro EXECUTE_PIPE_MUL_EN defined: MUL iterative multiplier and MUL state compiled in per REQ-020/024.
REQ-029 Macro undefined: no multiplier logic; alu_op 8 SHALL behave as pass operand B with latency 1; MUL state unreachable.

Verification
REQ-030 ADD op_a=0x7FFFFFFF, op_b=1 -> alu_out 0x80000000, flags N=1 V=1 Z=0 C=0, out_valid 1 cycle after transfer.
REQ-031 SUB 5-5 then branch EQ pc_in=0x0010 imm=0xFFFC -> pc_out 0x000C, flush 1; same with NE -> pc_out 0x0011, flush 0.
REQ-032 MUL (macro on) op_a=12, op_b=13 -> alu_out 156 after 33 cycles, in_ready 0 during MUL; macro off -> alu_out 13 after 1 cycle.
REQ-033 Back-to-back 4 ADDs with out_ready held 1 -> 4 results on consecutive cycles; out_ready 0 for 3 cycles -> outputs frozen, in_ready 0.
REQ-034 rst asserted mid-MUL cycle 10 -> out_valid never rises, in_ready 1 next cycle, flags 0.
REQ-035 Jump op_a=0x0001_2345, PC_W=16 -> pc_out 0x2345, flush 1; is_jump with is_branch, br_cond 5 -> still taken.

Source files
------------

// File: rtl/execute_pipe.sv
// execute_pipe: single-issue execute stage with ALU, branch resolution and an optional iterative multiplier (EXECUTE_PIPE_MUL_EN)
module execute_pipe #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [15:0]       imm,
  input  logic              a_imm,
  input  logic              b_imm,
  input  logic [3:0]        alu_op,
  input  logic              is_jump,
  input  logic              is_branch,
  input  logic [2:0]        br_cond,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out,
  output logic [PC_W-1:0]   pc_out,
  output logic              flush,
  output logic [3:0]        flags
);
  localparam int SH_W = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0] w_a, w_b, w_res, r_alu;
  logic [DATA_W:0] w_sum;
  logic [PC_W-1:0] w_pc_next, r_pc;
  logic [3:0] w_flags, r_flags;
  logic [SH_W-1:0] w_sh;
  logic w_is_sub, w_is_as, w_v, w_cond, w_taken, w_xfer, w_is_mul, w_mul_done, r_taken;
`ifdef EXECUTE_PIPE_MUL_EN
  logic [DATA_W-1:0] r_mcand, r_mplier;
  logic [SH_W-1:0] r_cnt;
  assign w_is_mul   = alu_op == 4'd8;
  assign w_mul_done = r_cnt == SH_W'(DATA_W - 1);
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_done = 1'b1;
`endif
  assign w_a      = a_imm ? DATA_W'($signed(imm)) : op_a;
  assign w_b      = b_imm ? DATA_W'($signed(imm)) : op_b;
  assign w_sh     = w_b[SH_W-1:0];
  assign w_is_sub = alu_op == 4'd1;
  assign w_is_as  = alu_op == 4'd0 || w_is_sub;
  assign w_sum    = {1'b0, w_a} + {1'b0, w_is_sub ? ~w_b : w_b} + (DATA_W+1)'(w_is_sub);
  assign w_v      = (w_a[DATA_W-1] == (w_is_sub ? ~w_b[DATA_W-1] : w_b[DATA_W-1])) && (w_sum[DATA_W-1] != w_a[DATA_W-1]);
  assign w_flags  = {w_sum[DATA_W-1:0] == '0, w_sum[DATA_W-1], w_sum[DATA_W], w_v};
  // ALU result for single-cycle ops; MUL and undefined codes fall through to operand B
  always_comb begin
    w_res = w_b;
    case (alu_op)
      4'd0, 4'd1: w_res = w_sum[DATA_W-1:0];
      4'd2: w_res = w_a & w_b;
      4'd3: w_res = w_a | w_b;
      4'd4: w_res = w_a ^ w_b;
      4'd5: w_res = w_a << w_sh;
      4'd6: w_res = w_a >> w_sh;
      4'd7: w_res = $signed(w_a) >>> w_sh;
      default: w_res = w_b;
    endcase
  end
  assign w_cond = br_cond == 3'd0 ? r_flags[3] :
                  br_cond == 3'd1 ? !r_flags[3] :
                  br_cond == 3'd2 ? r_flags[2] ^ r_flags[0] :
                  br_cond == 3'd3 ? !(r_flags[2] ^ r_flags[0]) :
                  br_cond == 3'd4;
  assign w_taken   = is_jump || (is_branch && w_cond);
  assign w_pc_next = is_jump ? PC_W'(op_a) : pc_in + (w_taken ? PC_W'($signed(imm)) : PC_W'(1));
  assign in_ready  = r_state == IDLE || (r_state == HOLD && out_ready);
  assign out_valid = r_state == HOLD;
  assign w_xfer    = in_valid && in_ready;
  assign alu_out   = r_alu;
  assign pc_out    = r_pc;
  assign flush     = out_valid && r_taken;
  assign flags     = r_flags;
  // state register; reset wins over any concurrent transfer
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // next state: a transfer always starts a new result, otherwise drain HOLD or keep iterating MUL
  always_comb begin
    w_next = IDLE;
    w_next = w_xfer ? (w_is_mul ? MUL : HOLD) :
             r_state == MUL ? (w_mul_done ? HOLD : MUL) :
             (r_state == HOLD && !out_ready) ? HOLD : IDLE;
  end
  // result, PC, branch outcome and flags captured at transfer; MUL accumulates into the result register
  always_ff @(posedge clk)
    if (rst) begin
      r_alu   <= '0;
      r_pc    <= '0;
      r_taken <= 1'b0;
      r_flags <= '0;
    end else if (w_xfer) begin
      r_alu   <= w_is_mul ? '0 : w_res;
      r_pc    <= w_pc_next;
      r_taken <= w_taken;
      if (w_is_as) r_flags <= w_flags;
    end
`ifdef EXECUTE_PIPE_MUL_EN
    else if (r_state == MUL) r_alu <= r_alu + (r_mplier[0] ? r_mcand : '0);
  // shift-add operands: one multiplier bit consumed per MUL cycle
  always_ff @(posedge clk)
    if (w_xfer) begin
      r_mcand  <= w_a;
      r_mplier <= w_b;
      r_cnt    <= '0;
    end else if (r_state == MUL) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: randomized and directed checks of execute_pipe against a transaction-level model
module tb_execute_pipe;
`ifdef EXECUTE_PIPE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  logic clk = 0, rst = 1, in_valid = 0, a_imm = 0, b_imm = 0, is_jump = 0, is_branch = 0, out_ready = 0;
  logic [15:0] pc_in = 0, imm = 0, pc_out;
  logic [31:0] op_a = 0, op_b = 0, alu_out;
  logic [3:0] alu_op = 0, flags;
  logic [2:0] br_cond = 0;
  logic in_ready, out_valid, flush;
  always #5 clk = ~clk;
  execute_pipe #(.DATA_W(32), .PC_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_in(pc_in),
    .op_a(op_a), .op_b(op_b), .imm(imm), .a_imm(a_imm), .b_imm(b_imm), .alu_op(alu_op),
    .is_jump(is_jump), .is_branch(is_branch), .br_cond(br_cond), .out_valid(out_valid),
    .out_ready(out_ready), .alu_out(alu_out), .pc_out(pc_out), .flush(flush), .flags(flags)
  );
  typedef struct {
    logic [31:0] alu;
    logic [15:0] pc;
    logic fl;
    int xc;
    int lat;
  } exp_t;
  exp_t q[$];
  logic [3:0] m_flags = 0;
  int cyc = 0, n_chk = 0, n_pass = 0;
  bit seen = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask
  task automatic push_model();
    logic [31:0] a, b, r;
    longint s;
    logic c, cond;
    exp_t e;
    a = a_imm ? {{16{imm[15]}}, imm} : op_a;
    b = b_imm ? {{16{imm[15]}}, imm} : op_b;
    s = 0;
    c = 0;
    case (alu_op)
      0: begin r = a + b; s = longint'($signed(a)) + longint'($signed(b)); c = (longint'(a) + longint'(b)) >= 64'sh100000000; end
      1: begin r = a - b; s = longint'($signed(a)) - longint'($signed(b)); c = a >= b; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a << b[4:0];
      6: r = a >> b[4:0];
      7: r = $signed(a) >>> b[4:0];
      8: r = MUL_EN ? a * b : b;
      default: r = b;
    endcase
    case (br_cond)
      0: cond = m_flags[3];
      1: cond = !m_flags[3];
      2: cond = m_flags[2] != m_flags[0];
      3: cond = m_flags[2] == m_flags[0];
      4: cond = 1;
      default: cond = 0;
    endcase
    e.fl = is_jump || (is_branch && cond);
    e.pc = is_jump ? op_a[15:0] : e.fl ? pc_in + imm : pc_in + 16'd1;
    e.alu = r;
    e.xc = cyc;
    e.lat = (MUL_EN && alu_op == 8) ? 33 : 1;
    if (alu_op < 2) m_flags = {r == 0, r[31], c, s != longint'($signed(r))};
    q.push_back(e);
  endtask
  task automatic cycle_end();
    #1;
    check("flags", 64'(flags), 64'(m_flags));
    if (q.size() == 0) begin
      check("idle_ov", 64'(out_valid), 64'd0);
      check("idle_rdy", 64'(in_ready), 64'd1);
    end else if (out_valid) begin
      if (!seen) check("latency", 64'(cyc - q[0].xc), 64'(q[0].lat));
      seen = 1;
      check("alu_out", 64'(alu_out), 64'(q[0].alu));
      check("pc_out", 64'(pc_out), 64'(q[0].pc));
      check("flush", 64'(flush), 64'(q[0].fl));
      check("hold_rdy", 64'(in_ready), 64'(out_ready));
    end else begin
      check("flush_lo", 64'(flush), 64'd0);
      if (q[0].lat > 1) check("mul_rdy", 64'(in_ready), 64'd0);
    end
    if (rst) begin
      q.delete();
      m_flags = 0;
      seen = 0;
    end else begin
      if (out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        seen = 0;
      end
      if (in_valid && in_ready) push_model();
    end
    @(negedge clk);
    cyc++;
  endtask
  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] im, input logic ai, input logic bi, input logic j, input logic br,
                       input logic [2:0] cnd, input logic [15:0] pc, input logic ordy);
    in_valid = v; alu_op = op; op_a = a; op_b = b; imm = im; a_imm = ai; b_imm = bi;
    is_jump = j; is_branch = br; br_cond = cnd; pc_in = pc; out_ready = ordy;
    cycle_end();
  endtask
  task automatic idle(input logic ordy);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ordy);
  endtask
  task automatic do_reset();
    rst = 1;
    in_valid = 1;
    cycle_end();
    rst = 0;
    in_valid = 0;
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 8));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int n;
    @(negedge clk);
    cycle_end();
    cycle_end();
    rst = 0;
    check("rst_ov", 64'(out_valid), 64'd0);
    check("rst_rdy", 64'(in_ready), 64'd1);
    check("rst_alu", 64'(alu_out), 64'd0);
    check("rst_pc", 64'(pc_out), 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    drive(1, 0, 32'h7FFF_FFFF, 1, 0, 0, 0, 0, 0, 0, 16'h0100, 0);
    check("add_ovf", 64'(alu_out), 64'h8000_0000);
    check("add_flags", 64'(flags), 64'b0101);
    check("add_lat", 64'(out_valid), 64'd1);
    drive(1, 1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 2, 0, 0, 16'hFFFC, 0, 0, 0, 1, 0, 16'h0010, 1);
    check("beq_pc", 64'(pc_out), 64'h000C);
    check("beq_flush", 64'(flush), 64'd1);
    drive(1, 2, 0, 0, 16'hFFFC, 0, 0, 0, 1, 1, 16'h0010, 1);
    check("bne_pc", 64'(pc_out), 64'h0011);
    check("bne_flush", 64'(flush), 64'd0);
    drive(1, 9, 32'h0001_2345, 0, 0, 0, 0, 1, 0, 0, 16'h0040, 1);
    check("jmp_pc", 64'(pc_out), 64'h2345);
    check("jmp_flush", 64'(flush), 64'd1);
    drive(1, 9, 32'h0000_BEEF, 0, 0, 0, 0, 1, 1, 5, 16'h0040, 1);
    check("jmpbr_pc", 64'(pc_out), 64'hBEEF);
    check("jmpbr_flush", 64'(flush), 64'd1);
    for (int i = 0; i < 4; i++) drive(1, 0, 32'(i * 3), 7, 0, 0, 0, 0, 0, 0, 16'(i), 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 99, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("stall_rdy", 64'(in_ready), 64'd0);
    end
    idle(1);
    drive(1, 8, 12, 13, 0, 0, 0, 0, 0, 0, 16'h0200, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      idle(0);
      n++;
    end
    check("mul_done", 64'(out_valid), 64'd1);
    check("mul_res", 64'(alu_out), MUL_EN ? 64'd156 : 64'd13);
    idle(1);
    drive(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 8, 12, 13, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (9) idle(0);
    do_reset();
    check("abort_rdy", 64'(in_ready), 64'd1);
    check("abort_flags", 64'(flags), 64'd0);
    check("abort_ov", 64'(out_valid), 64'd0);
    repeat (40) idle(1);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else drive($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), pick(), pick(), 16'($urandom),
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 9) < 7);
    end
    repeat (40) idle(1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
